ls_access_ctrl: RTL

Initiator-side controller for the SPU local store (exmemory). It arbitrates one access per cycle between the core's quadword load/store port and an autonomous sequential instruction-fetch engine. It drives fetchinstr/memread/memwrite/adr/writedata, and collects the memory's one-cycle-latency read results. Fetched instruction pairs are buffered in a 2-entry queue for decode; load data is returned with a valid strobe.

---
 rtl/ls_access_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ls_access_ctrl.sv
// Local-store initiator: arbitrates core quadword load/store against a sequential
// instruction-fetch engine and buffers fetched instruction pairs in a 2-entry queue.
module ls_access_ctrl #(
    parameter int          RFWIDTH = 128,
    parameter int          WIDTH   = 32,
    parameter logic [31:0] LSLR    = 32'h00003FFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [WIDTH-1:0]   ls_addr,
    input  logic [RFWIDTH-1:0] ls_wdata,
    output logic               ls_gnt,
    output logic               ld_valid,
    output logic [RFWIDTH-1:0] ld_data,
    input  logic               redirect,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               ib_valid,
    input  logic               ib_ready,
    output logic [WIDTH-1:0]   ib_instr0,
    output logic [WIDTH-1:0]   ib_instr1,
    output logic [WIDTH-1:0]   ib_pc,
    output logic               fetchinstr,
    output logic               memread,
    output logic               memwrite,
    output logic [WIDTH-1:0]   adr,
    output logic [RFWIDTH-1:0] writedata,
    input  logic [WIDTH-1:0]   instr0,
    input  logic [WIDTH-1:0]   instr1,
    input  logic [RFWIDTH-1:0] memdata
);

    localparam logic [WIDTH-1:0] LS_MASK = WIDTH'(LSLR);
    localparam logic [WIDTH-1:0] QW_MASK = LS_MASK & ~WIDTH'(32'hF);
    localparam logic [WIDTH-1:0] DW_MASK = LS_MASK & ~WIDTH'(32'h7);

    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_inflight_pc;
    logic             r_inflight;
    logic             r_squash;
    logic             r_ld_pend;
    logic [2:0]       r_starve;
    logic [1:0]       r_count;
    logic             r_head;
    logic [WIDTH-1:0] r_q_i0 [2];
    logic [WIDTH-1:0] r_q_i1 [2];
    logic [WIDTH-1:0] r_q_pc [2];

    logic             w_room;
    logic             w_override;
    logic             w_gnt;
    logic             w_fetch;
    logic             w_push;
    logic             w_pop;
    logic             w_ib_valid;
    logic             w_tail;
    logic [WIDTH-1:0] w_fetch_adr;

    // Room counts the in-flight fetch so the queue can never overflow.
    assign w_room      = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2;
    assign w_override  = (r_starve == 3'd4);
    assign w_gnt       = reset_n & ls_req & ~w_override;
    assign w_fetch     = reset_n & ~redirect & ~w_gnt & w_room;
    assign w_ib_valid  = (r_count != 2'd0);
    assign w_push      = r_inflight & ~r_squash & ~redirect;
    assign w_pop       = w_ib_valid & ib_ready & ~redirect;
    assign w_tail      = r_head ^ r_count[0];
    assign w_fetch_adr = r_fetch_pc & DW_MASK;

    assign ls_gnt     = w_gnt;
    assign memwrite   = w_gnt & ls_we;
    assign memread    = w_gnt & ~ls_we;
    assign fetchinstr = w_fetch;
    assign adr        = w_gnt ? (ls_addr & QW_MASK) : (w_fetch ? w_fetch_adr : '0);
    assign writedata  = (w_gnt & ls_we) ? ls_wdata : '0;

    assign ld_valid  = r_ld_pend;
    assign ld_data   = r_ld_pend ? memdata : '0;

    assign ib_valid  = w_ib_valid;
    assign ib_instr0 = w_ib_valid ? r_q_i0[r_head] : '0;
    assign ib_instr1 = w_ib_valid ? r_q_i1[r_head] : '0;
    assign ib_pc     = w_ib_valid ? r_q_pc[r_head] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= '0;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_squash      <= 1'b0;
            r_ld_pend     <= 1'b0;
            r_starve      <= '0;
        end else begin
            r_inflight <= w_fetch;
            r_squash   <= redirect & r_inflight;
            r_ld_pend  <= w_gnt & ~ls_we;
            if (w_fetch)
                r_inflight_pc <= w_fetch_adr;
            if (redirect)
                r_fetch_pc <= redirect_pc & DW_MASK;
            else if (w_fetch)
                r_fetch_pc <= (r_fetch_pc + WIDTH'(8)) & DW_MASK;
            if (redirect || w_fetch)
                r_starve <= '0;
            else if (ls_req && w_room)
                r_starve <= r_starve + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_head  <= 1'b0;
        end else if (redirect) begin
            r_count <= '0;
            r_head  <= 1'b0;
        end else begin
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_i0[w_tail] <= instr0;
            r_q_i1[w_tail] <= instr1;
            r_q_pc[w_tail] <= r_inflight_pc;
        end
    end

endmodule
